monitoreo_multicanal: RTL and testbench
=======================================

Name: monitoreo_multicanal

Overview:
Parametrised multi-channel successor of the single-channel temperature monitor. Each of NUM_CH channels runs an independent NORMAL/BAJO/ALTO/ALERTA state machine with a persistence counter and configurable thresholds. Channels can optionally apply hysteresis on return to NORMAL. All channels drive per-channel heater and fan commands, and a global alert is the OR of all channel alerts. The block sits between the sensor sampling front-end and the actuator/alarm logic.

Parameters:
NUM_CH, 4, number of independent channels
TEMP_W, 10, width of each temperature sample (unsigned)
T_BAJO, 180, a sample below this value is cold (frio)
T_ALTO, 260, a sample at or above this value is hot (calor)
HYST, 0, hysteresis margin applied only when leaving BAJO/ALTO/ALERTA toward NORMAL
N_PERS, 5, consecutive out-of-range valid samples needed to enter ALERTA
CNT_W, 4, persistence counter width per channel

Ports:
clk  in  1  clock, all logic on rising edge
srst  in  1  synchronous reset, active-high
temp_entrada  in  NUM_CH*TEMP_W  packed samples; channel i occupies bits [i*TEMP_W +: TEMP_W]
temp_valida  in  NUM_CH  per-channel sample-valid strobe
ack_alerta  in  NUM_CH  per-channel alert acknowledge (used only with ALERTA_LATCH_EN)
estado_actual  out  2*NUM_CH  per-channel state: 00 NORMAL, 01 BAJO, 10 ALTO, 11 ALERTA
contador_salida  out  CNT_W*NUM_CH  per-channel persistence counter
calefactor  out  NUM_CH  heater on
ventilador  out  NUM_CH  fan on
alerta_canal  out  NUM_CH  channel in ALERTA
alerta  out  1  OR of alerta_canal

Behaviour:
- Reset, when srst=1 at a clk edge, with priority over everything:
  - every channel goes to NORMAL with counter 0;
  - all outputs are 0 and the alert cause register is cleared.
- Per-sample classification:
  - frio: temp < T_BAJO;
  - calor: temp >= T_ALTO;
  - otherwise in-range.
  - Return-to-normal condition (vuelta): T_BAJO+HYST <= temp < T_ALTO-HYST.
- Sample handling: a channel advances only on edges where temp_valida[i]=1. With temp_valida[i]=0, state, counter and outputs hold.
- NORMAL:
  - frio -> BAJO, cnt=1;
  - calor -> ALTO, cnt=1;
  - in-range -> stay, cnt=0.
- BAJO:
  - frio -> cnt+1; if cnt+1 == N_PERS -> ALERTA with cause=frio;
  - calor -> ALTO, cnt=1;
  - vuelta -> NORMAL, cnt=0;
  - in-range but not vuelta (hysteresis band) -> hold state and cnt.
- ALTO: mirror of BAJO (calor counts; frio -> BAJO, cnt=1; entering ALERTA sets cause=calor).
- ALERTA:
  - cnt saturates at N_PERS;
  - frio or calor -> stay, cause updated to the latest extreme;
  - vuelta -> NORMAL, cnt=0 (see Optional Feature).
- N_PERS=1: the first out-of-range sample goes NORMAL -> ALERTA directly.
- Registered outputs, decoded from next state:
  - calefactor = BAJO or (ALERTA and cause=frio);
  - ventilador = ALTO or (ALERTA and cause=calor);
  - alerta_canal = ALERTA.
  - Latency: a sample presented in cycle k is reflected on all outputs after edge k+1.
  - calefactor and ventilador are never both 1 on the same channel.
- Channels are fully independent. Simultaneous valids on several channels are all processed in the same cycle.
- Elaboration checks, enforced with a fatal assertion: T_BAJO+HYST <= T_ALTO-HYST, N_PERS >= 1, N_PERS < 2**CNT_W, T_ALTO < 2**TEMP_W.

Optional Feature:
ALERTA_LATCH_EN
- Defined:
  - ALERTA exits to NORMAL only on an edge where ack_alerta[i]=1 and the current valid sample satisfies vuelta;
  - a vuelta sample without ack holds ALERTA and sets cause to none, so calefactor and ventilador go to 0 while alerta_canal stays 1;
  - ack_alerta[i] is ignored in any state other than ALERTA.
- Undefined: ack_alerta is ignored and ALERTA recovers automatically on a vuelta sample.

Test Plan:
1. srst=1 mid-ALERTA on ch0 -> after the next edge all estado_actual=00, contador_salida=0, alerta=0.
2. ch1 valid samples 150,120,170,100,179 -> estado 01 with cnt 1..4, then 11 after the 5th; calefactor[1]=1 throughout; alerta=1; other channels stay 00.
3. ch2 samples 300,300,220 -> ALTO cnt=2, then NORMAL cnt=0; alerta_canal[2] never 1 (transient ignored).
4. Limits on ch0 with HYST=0: 179 then 180 -> 01 then 00; 259 then 260 -> 00 then 10. With HYST=5: 182 after BAJO -> stays 01; 185 -> 00.
5. ch3 at ALERTA (cold), then samples 300 and 220 -> stays 11 with ventilador=1 and calefactor=0, then 00 (auto). With ALERTA_LATCH_EN: 220 without ack -> stays 11 with both actuators 0; 220 with ack_alerta[3]=1 -> 00.
6. ch0 cold samples interleaved with temp_valida=0 gaps, all channels driven concurrently -> counters advance only on valid samples, and channels do not interact.

Source files
------------

// File: rtl/monitoreo_multicanal.sv
// Multi-channel temperature monitor: per-channel NORMAL/BAJO/ALTO/ALERTA FSM.
// Optional macro ALERTA_LATCH_EN: ALERTA exits only on vuelta with ack.
module monitoreo_multicanal #(
  parameter int NUM_CH = 4,
  parameter int TEMP_W = 10,
  parameter int T_BAJO = 180,
  parameter int T_ALTO = 260,
  parameter int HYST   = 0,
  parameter int N_PERS = 5,
  parameter int CNT_W  = 4
) (
  input  logic                     clk,
  input  logic                     srst,
  input  logic [NUM_CH*TEMP_W-1:0] temp_entrada,
  input  logic [NUM_CH-1:0]        temp_valida,
  input  logic [NUM_CH-1:0]        ack_alerta,
  output logic [2*NUM_CH-1:0]      estado_actual,
  output logic [CNT_W*NUM_CH-1:0]  contador_salida,
  output logic [NUM_CH-1:0]        calefactor,
  output logic [NUM_CH-1:0]        ventilador,
  output logic [NUM_CH-1:0]        alerta_canal,
  output logic                     alerta
);

  typedef enum logic [1:0] {
    NORMAL = 2'b00,
    BAJO   = 2'b01,
    ALTO   = 2'b10,
    ALERTA = 2'b11
  } est_t;

  typedef enum logic [1:0] {
    C_NONE  = 2'b00,
    C_FRIO  = 2'b01,
    C_CALOR = 2'b10
  } causa_t;

  localparam logic [TEMP_W-1:0] LIM_BAJO = TEMP_W'(T_BAJO);
  localparam logic [TEMP_W-1:0] LIM_ALTO = TEMP_W'(T_ALTO);
  localparam logic [TEMP_W-1:0] VUEL_LO  = TEMP_W'(T_BAJO + HYST);
  localparam logic [TEMP_W-1:0] VUEL_HI  = TEMP_W'(T_ALTO - HYST);
  localparam logic [CNT_W-1:0]  NP       = CNT_W'(N_PERS);
  localparam logic [CNT_W-1:0]  UNO      = CNT_W'(1);

  if (T_BAJO + HYST > T_ALTO - HYST) begin : g_chk_hyst
    $fatal(1, "hysteresis band overlaps thresholds");
  end
  if (N_PERS < 1) begin : g_chk_np_min
    $fatal(1, "N_PERS must be at least 1");
  end
  if (N_PERS >= (1 << CNT_W)) begin : g_chk_np_max
    $fatal(1, "N_PERS does not fit in CNT_W");
  end
  if (T_ALTO >= (1 << TEMP_W)) begin : g_chk_talto
    $fatal(1, "T_ALTO does not fit in TEMP_W");
  end

  est_t             est_q   [NUM_CH];
  est_t             est_d   [NUM_CH];
  logic [CNT_W-1:0] cnt_q   [NUM_CH];
  logic [CNT_W-1:0] cnt_d   [NUM_CH];
  causa_t           causa_q [NUM_CH];
  causa_t           causa_d [NUM_CH];

  logic [NUM_CH-1:0] frio;
  logic [NUM_CH-1:0] calor;
  logic [NUM_CH-1:0] vuelta;
  logic [NUM_CH-1:0] cal_d;
  logic [NUM_CH-1:0] ven_d;
  logic [NUM_CH-1:0] ala_d;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [TEMP_W-1:0] t;
    assign t         = temp_entrada[g*TEMP_W +: TEMP_W];
    assign frio[g]   = t < LIM_BAJO;
    assign calor[g]  = t >= LIM_ALTO;
    assign vuelta[g] = (t >= VUEL_LO) && (t < VUEL_HI);
    assign estado_actual[2*g +: 2]       = est_q[g];
    assign contador_salida[CNT_W*g +: CNT_W] = cnt_q[g];
  end

`ifndef ALERTA_LATCH_EN
  logic unused_ack;
  assign unused_ack = &{1'b0, ack_alerta};
`endif

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      est_d[i]   = est_q[i];
      cnt_d[i]   = cnt_q[i];
      causa_d[i] = causa_q[i];
      if (temp_valida[i]) begin
        unique case (est_q[i])
          NORMAL: begin
            unique case (1'b1)
              frio[i]: begin
                est_d[i]   = BAJO;
                cnt_d[i]   = UNO;
                causa_d[i] = C_FRIO;
              end
              calor[i]: begin
                est_d[i]   = ALTO;
                cnt_d[i]   = UNO;
                causa_d[i] = C_CALOR;
              end
              default: cnt_d[i] = '0;
            endcase
          end
          BAJO: begin
            unique case (1'b1)
              frio[i]: cnt_d[i] = cnt_q[i] + UNO;
              calor[i]: begin
                est_d[i]   = ALTO;
                cnt_d[i]   = UNO;
                causa_d[i] = C_CALOR;
              end
              vuelta[i]: begin
                est_d[i]   = NORMAL;
                cnt_d[i]   = '0;
                causa_d[i] = C_NONE;
              end
              default: ;
            endcase
          end
          ALTO: begin
            unique case (1'b1)
              calor[i]: cnt_d[i] = cnt_q[i] + UNO;
              frio[i]: begin
                est_d[i]   = BAJO;
                cnt_d[i]   = UNO;
                causa_d[i] = C_FRIO;
              end
              vuelta[i]: begin
                est_d[i]   = NORMAL;
                cnt_d[i]   = '0;
                causa_d[i] = C_NONE;
              end
              default: ;
            endcase
          end
          ALERTA: begin
            cnt_d[i] = NP;
            unique case (1'b1)
              frio[i]:  causa_d[i] = C_FRIO;
              calor[i]: causa_d[i] = C_CALOR;
              vuelta[i]: begin
                causa_d[i] = C_NONE;
`ifdef ALERTA_LATCH_EN
                if (ack_alerta[i]) begin
                  est_d[i] = NORMAL;
                  cnt_d[i] = '0;
                end
`else
                est_d[i] = NORMAL;
                cnt_d[i] = '0;
`endif
              end
              default: ;
            endcase
          end
        endcase
        // persistence reached: covers N_PERS=1 straight from NORMAL
        if ((est_d[i] inside {BAJO, ALTO}) && cnt_d[i] == NP)
          est_d[i] = ALERTA;
      end
      cal_d[i] = (est_d[i] == BAJO) ||
                 (est_d[i] == ALERTA && causa_d[i] == C_FRIO);
      ven_d[i] = (est_d[i] == ALTO) ||
                 (est_d[i] == ALERTA && causa_d[i] == C_CALOR);
      ala_d[i] = est_d[i] == ALERTA;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        est_q[i]   <= NORMAL;
        cnt_q[i]   <= '0;
        causa_q[i] <= C_NONE;
      end
      calefactor   <= '0;
      ventilador   <= '0;
      alerta_canal <= '0;
      alerta       <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        est_q[i]   <= est_d[i];
        cnt_q[i]   <= cnt_d[i];
        causa_q[i] <= causa_d[i];
      end
      calefactor   <= cal_d;
      ventilador   <= ven_d;
      alerta_canal <= ala_d;
      alerta       <= |ala_d;
    end
  end

endmodule

// File: tb/tb_monitoreo_multicanal.sv
// Randomized bench for monitoreo_multicanal against a behavioural model.
// Two instances run the same stimulus: HYST=0 and HYST=5.
module tb_monitoreo_multicanal;

  localparam int NC = 4;
  localparam int TW = 10;
  localparam int CW = 4;
  localparam int NP = 5;
`ifdef ALERTA_LATCH_EN
  localparam bit LATCH = 1'b1;
`else
  localparam bit LATCH = 1'b0;
`endif

  logic clk = 1'b0;
  logic srst;
  logic [NC*TW-1:0] temp_entrada;
  logic [NC-1:0] temp_valida;
  logic [NC-1:0] ack_alerta;

  logic [2*NC-1:0]  est_a, est_b;
  logic [CW*NC-1:0] cnt_a, cnt_b;
  logic [NC-1:0]    cal_a, cal_b;
  logic [NC-1:0]    ven_a, ven_b;
  logic [NC-1:0]    alc_a, alc_b;
  logic             al_a, al_b;

  int errors = 0;
  int checks = 0;

  int mst  [2][NC];
  int mcnt [2][NC];
  int mcz  [2][NC];

  always #5 clk = ~clk;

  monitoreo_multicanal #(.HYST(0)) u_h0 (
    .clk(clk), .srst(srst),
    .temp_entrada(temp_entrada), .temp_valida(temp_valida),
    .ack_alerta(ack_alerta),
    .estado_actual(est_a), .contador_salida(cnt_a),
    .calefactor(cal_a), .ventilador(ven_a),
    .alerta_canal(alc_a), .alerta(al_a)
  );

  monitoreo_multicanal #(.HYST(5)) u_h5 (
    .clk(clk), .srst(srst),
    .temp_entrada(temp_entrada), .temp_valida(temp_valida),
    .ack_alerta(ack_alerta),
    .estado_actual(est_b), .contador_salida(cnt_b),
    .calefactor(cal_b), .ventilador(ven_b),
    .alerta_canal(alc_b), .alerta(al_b)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // state codes: 0 normal, 1 cold, 2 hot, 3 alert; cause 0/1 cold/2 hot
  task automatic paso(input int hy, input int t, input bit ack,
                      inout int st, inout int cnt, inout int cz);
    bit fr, ca, vu;
    int dir;
    fr = t < 180;
    ca = t >= 260;
    vu = (t >= 180 + hy) && (t < 260 - hy);
    if (st == 3) begin
      if (fr) cz = 1;
      else if (ca) cz = 2;
      else if (vu) begin
        cz = 0;
        if (!LATCH || ack) begin
          st = 0;
          cnt = 0;
        end
      end
    end else if (fr || ca) begin
      dir = fr ? 1 : 2;
      cnt = (st == dir) ? cnt + 1 : 1;
      st = dir;
      cz = dir;
      if (cnt >= NP) begin
        st = 3;
        cnt = NP;
      end
    end else if (st == 0 || vu) begin
      st = 0;
      cnt = 0;
      cz = 0;
    end
  endtask

  task automatic comparar(input int d, input logic [2*NC-1:0] est,
                          input logic [CW*NC-1:0] cnt,
                          input logic [NC-1:0] cal,
                          input logic [NC-1:0] ven,
                          input logic [NC-1:0] alc,
                          input logic al);
    logic [2*NC-1:0]  e_est;
    logic [CW*NC-1:0] e_cnt;
    logic [NC-1:0]    e_cal, e_ven, e_alc;
    for (int i = 0; i < NC; i++) begin
      e_est[2*i +: 2]   = 2'(mst[d][i]);
      e_cnt[CW*i +: CW] = CW'(mcnt[d][i]);
      e_cal[i] = mst[d][i] == 1 || (mst[d][i] == 3 && mcz[d][i] == 1);
      e_ven[i] = mst[d][i] == 2 || (mst[d][i] == 3 && mcz[d][i] == 2);
      e_alc[i] = mst[d][i] == 3;
    end
    chk($sformatf("estado_h%0d", d), 32'(est), 32'(e_est));
    chk($sformatf("contador_h%0d", d), 32'(cnt), 32'(e_cnt));
    chk($sformatf("calefactor_h%0d", d), 32'(cal), 32'(e_cal));
    chk($sformatf("ventilador_h%0d", d), 32'(ven), 32'(e_ven));
    chk($sformatf("alerta_canal_h%0d", d), 32'(alc), 32'(e_alc));
    chk($sformatf("alerta_h%0d", d), 32'(al), 32'(|e_alc));
    chk($sformatf("exclusivo_h%0d", d), 32'(cal & ven), 32'(0));
  endtask

  task automatic comparar_todo();
    comparar(0, est_a, cnt_a, cal_a, ven_a, alc_a, al_a);
    comparar(1, est_b, cnt_b, cal_b, ven_b, alc_b, al_b);
  endtask

  task automatic ciclo(input int t [NC], input logic [NC-1:0] v,
                       input logic [NC-1:0] a);
    for (int i = 0; i < NC; i++)
      temp_entrada[i*TW +: TW] = TW'(t[i]);
    temp_valida = v;
    ack_alerta  = a;
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < NC; i++)
        if (v[i])
          paso(d ? 5 : 0, t[i], a[i], mst[d][i], mcnt[d][i], mcz[d][i]);
    comparar_todo();
  endtask

  task automatic uno(input int ch, input int t, input bit a = 1'b0);
    int tt [NC];
    logic [NC-1:0] v;
    tt = '{default: 200};
    tt[ch] = t;
    v = NC'(1) << ch;
    ciclo(tt, v, a ? v : '0);
  endtask

  task automatic reset();
    srst = 1'b1;
    temp_valida = NC'($urandom);
    temp_entrada = '0;
    @(posedge clk);
    #1;
    srst = 1'b0;
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < NC; i++) begin
        mst[d][i] = 0;
        mcnt[d][i] = 0;
        mcz[d][i] = 0;
      end
    comparar_todo();
  endtask

  function automatic int rtemp();
    case ($urandom_range(0, 3))
      0: return $urandom_range(0, 1023);
      1: return $urandom_range(170, 195);
      2: return $urandom_range(245, 270);
      default: return $urandom_range(100, 320);
    endcase
  endfunction

  initial begin
    int tt [NC];
    srst = 1'b1;
    temp_entrada = '0;
    temp_valida = '0;
    ack_alerta = '0;
    reset();

    // alert on ch0, then reset in the middle of it
    repeat (6) uno(0, 100);
    reset();

    // ch1 cold persistence to alert
    uno(1, 150);
    uno(1, 120);
    uno(1, 170);
    uno(1, 100);
    uno(1, 179);

    // ch2 transient heat
    uno(2, 300);
    uno(2, 300);
    uno(2, 220);

    // threshold limits and hysteresis band on ch0
    uno(0, 179);
    uno(0, 180);
    uno(0, 259);
    uno(0, 260);
    uno(0, 220);
    uno(0, 100);
    uno(0, 182);
    uno(0, 185);

    // ch3 cold alert, flip to hot, return with and without ack
    repeat (5) uno(3, 100);
    uno(3, 300);
    uno(3, 220);
    uno(3, 220, 1'b1);
    uno(3, 220, 1'b1);

    // ch0 cold with gaps while other channels run
    for (int k = 0; k < 14; k++) begin
      logic [NC-1:0] v;
      for (int i = 1; i < NC; i++) tt[i] = rtemp();
      tt[0] = 100;
      v = NC'($urandom);
      v[0] = k[0];
      ciclo(tt, v, '0);
    end

    for (int k = 0; k < 800; k++) begin
      if ($urandom_range(0, 99) == 0) reset();
      else begin
        for (int i = 0; i < NC; i++) tt[i] = rtemp();
        ciclo(tt, NC'($urandom), NC'($urandom));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
